// File: rtl/stack_engine.sv
// stack_engine: multi-cycle PUSH/POP/PEEK sequencer between the control unit
// and the register file. It performs one stack memory access over a
// req/ack bus, then drives the single register-file write port for up to
// two write-back cycles: the destination register, then SP.
module stack_engine #(
  parameter logic [15:0] STACK_BASE  = 16'hFF00,  // empty-stack SP value
  parameter logic [15:0] STACK_LIMIT = 16'hFE00   // full-stack boundary
) (
  input  logic        clk,
  input  logic        rst,
  // command interface
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_reg,
  // register file read side
  input  logic [15:0] reg_a,
  input  logic [15:0] reg_x,
  input  logic [15:0] reg_y,
  input  logic [15:0] reg_sp,
  // register file write port
  output logic [2:0]  rf_reg_sel,
  output logic [15:0] rf_data,
  output logic        rf_write_en,
  // stack memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  // completion status
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [2:0] SEL_SP  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_WB_REG,
    S_WB_SP,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;        // latched command opcode
  logic [2:0]  reg_q, reg_d;      // latched destination/source register
  logic [15:0] sp_q, sp_d;        // SP as seen at accept
  logic [15:0] wdata_q, wdata_d;  // PUSH source value
  logic [15:0] rdata_q, rdata_d;  // data returned by the memory read

  logic [15:0] src_val;
  logic        cmd_err;

  // Source register mux and accept-time legality checks.
  always_comb begin
    unique case (cmd_reg)
      3'd0:    src_val = reg_a;
      3'd1:    src_val = reg_x;
      3'd2:    src_val = reg_y;
      default: src_val = 16'h0000;
    endcase
    cmd_err = (cmd_op == 2'b11)
           || (cmd_reg > 3'd2)
           || ((cmd_op == OP_PUSH) && (reg_sp <= STACK_LIMIT))
           || ((cmd_op != OP_PUSH) && (reg_sp >= STACK_BASE));
  end

  // Next-state and latched-operand logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    reg_d   = reg_q;
    sp_d    = sp_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          reg_d = cmd_reg;
          sp_d  = reg_sp;
          if (cmd_op == OP_PUSH) wdata_d = src_val;
          state_d = cmd_err ? S_ERR : S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = (op_q == OP_PUSH) ? S_WB_SP : S_WB_REG;
        end
      end
      S_WB_REG: state_d = (op_q == OP_POP) ? S_WB_SP : S_IDLE;
      S_WB_SP:  state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and operand registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order or of other clocked processes.
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      reg_q   <= 3'd0;
      sp_q    <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      sp_q    <= sp_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from state only, so an async reset clears them at once.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    rf_write_en = 1'b0;
    rf_reg_sel  = 3'd0;
    rf_data     = 16'h0000;
    done        = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      S_MEM: begin
        mem_req = 1'b1;
        if (op_q == OP_PUSH) begin
          mem_we    = 1'b1;
          mem_addr  = sp_q - 16'd1;
          mem_wdata = wdata_q;
        end else begin
          mem_addr = sp_q;
        end
      end
      S_WB_REG: begin
        rf_write_en = 1'b1;
        rf_reg_sel  = reg_q;
        rf_data     = rdata_q;
        done        = (op_q == OP_PEEK);
      end
      S_WB_SP: begin
        rf_write_en = 1'b1;
        rf_reg_sel  = SEL_SP;
        rf_data     = (op_q == OP_PUSH) ? (sp_q - 16'd1) : (sp_q + 16'd1);
        done        = 1'b1;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: directed scenarios plus randomized commands for
// stack_engine, checked against a behavioural model of the stack rules.
// The bench plays both the register file and the stack memory.
module tb_stack_engine;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] LIMIT = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_reg = 3'd0;
  logic [15:0] reg_a = 16'h0, reg_x = 16'h0, reg_y = 16'h0, reg_sp = BASE;
  logic [2:0]  rf_reg_sel;
  logic [15:0] rf_data;
  logic        rf_write_en;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic        done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem_store [logic [15:0]];

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
  } wr_t;

  stack_engine #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp),
    .rf_reg_sel(rf_reg_sel), .rf_data(rf_data), .rf_write_en(rf_write_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem_store.exists(a) ? mem_store[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] reg_val(input logic [2:0] r);
    case (r)
      3'd0:    return reg_a;
      3'd1:    return reg_x;
      3'd2:    return reg_y;
      default: return 16'h0;
    endcase
  endfunction

  task automatic rf_apply(input logic [2:0] sel, input logic [15:0] d);
    case (sel)
      3'd0: reg_a = d;
      3'd1: reg_x = d;
      3'd2: reg_y = d;
      3'd3: reg_sp = d;
      default: ;
    endcase
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_quiet"}, {mem_req, mem_we, rf_write_en, done, err}, 0);
    check({tag, "_buses"}, {mem_addr, mem_wdata, rf_data, 13'd0, rf_reg_sel}, 0);
  endtask

  // Issue one command starting at a negedge; returns at the negedge of the
  // done cycle. exp_wait is the expected number of not-ready cycles before
  // acceptance (-1 = don't care).
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] rg,
                        input int ack_dly, input int exp_wait, input string name);
    int          waits = 0;
    int          cyc;
    int          mem_cycles = 0;
    bit          seen_done = 0;
    logic        e;
    logic [15:0] sp;
    int          lat;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [15:0] exp_addr;

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rg;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      check({name, "_accept_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) check({name, "_accept_wait"}, waits, exp_wait);

    // Reference model of the command, from the values seen at accept.
    sp = reg_sp;
    e  = (op == 2'b11) || (rg > 3'd2) || (op == 2'b00 && sp <= LIMIT)
      || (op != 2'b00 && sp >= BASE);
    exp_addr = (op == 2'b00) ? sp - 16'd1 : sp;
    if (!e) begin
      if (op == 2'b00) begin
        exp_q.push_back('{sel: 3'd3, data: sp - 16'd1});
      end else begin
        exp_q.push_back('{sel: rg, data: mem_read(sp)});
        if (op == 2'b01) exp_q.push_back('{sel: 3'd3, data: sp + 16'd1});
      end
    end
    lat = e ? 1 : ((op == 2'b01) ? 3 : 2) + ack_dly;

    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_reg   = 3'($urandom);
    cyc = 1;
    while (cyc <= 60) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        mem_cycles++;
        if (!e) begin
          check({name, "_mem_addr"}, mem_addr, exp_addr);
          check({name, "_mem_we"}, mem_we, (op == 2'b00));
          if (op == 2'b00) check({name, "_mem_wdata"}, mem_wdata, reg_val(rg));
        end
        if (mem_cycles == ack_dly + 1) begin
          mem_ack = 1'b1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else        mem_rdata = mem_read(mem_addr);
        end
      end else begin
        mem_ack = ($urandom_range(3) == 0);  // stray ack outside MEM
      end
      if (rf_write_en) begin
        obs_q.push_back('{sel: rf_reg_sel, data: rf_data});
        rf_apply(rf_reg_sel, rf_data);
      end
      if (done) begin
        seen_done = 1;
        check({name, "_latency"}, cyc, lat);
        check({name, "_err"}, err, e);
        break;
      end
      if (err) check({name, "_err_without_done"}, err, 0);
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    if (!seen_done) check({name, "_done_timeout"}, 0, 1);
    check({name, "_mem_cycles"}, mem_cycles, e ? 0 : ack_dly + 1);
    check({name, "_rf_writes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_rf_write%0d", name, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    check_idle_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");

    // PUSH X from an empty stack.
    reg_x = 16'h1234;
    reg_sp = BASE;
    do_cmd(2'b00, 3'd1, 0, 0, "push_x");
    check("push_x_sp", reg_sp, 16'hFEFF);
    check("push_x_mem", mem_read(16'hFEFF), 16'h1234);

    // POP into Y with a delayed ack (three MEM cycles).
    mem_store[16'hFEFF] = 16'hBEEF;
    do_cmd(2'b01, 3'd2, 2, 1, "pop_y");
    check("pop_y_val", reg_y, 16'hBEEF);
    check("pop_y_sp", reg_sp, BASE);

    // PEEK into A.
    @(negedge clk);
    reg_sp = 16'hFEF0;
    mem_store[16'hFEF0] = 16'hCAFE;
    do_cmd(2'b10, 3'd0, 0, 0, "peek_a");
    check("peek_a_val", reg_a, 16'hCAFE);
    check("peek_a_sp", reg_sp, 16'hFEF0);

    // Error cases.
    @(negedge clk);
    reg_sp = LIMIT;
    do_cmd(2'b00, 3'd0, 0, 0, "err_overflow");
    @(negedge clk);
    reg_sp = BASE;
    do_cmd(2'b01, 3'd1, 0, 0, "err_underflow");
    @(negedge clk);
    reg_sp = 16'hFEF0;
    do_cmd(2'b11, 3'd0, 0, 0, "err_op");
    @(negedge clk);
    do_cmd(2'b00, 3'd3, 0, 0, "err_reg");

    // Async reset during WB_REG of a POP.
    @(negedge clk);
    reg_sp = 16'hFEF0;
    mem_store[16'hFEF0] = 16'h7777;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_reg = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_pop_in_mem", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_pop_wb_reg", {rf_write_en, rf_reg_sel}, {1'b1, 3'd1});
    #2 rst = 1'b1;
    #1 check_idle_outputs("rst_pop_cleared");
    @(posedge clk);
    check("rst_pop_no_write_at_edge", rf_write_en, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pop_ready_after", cmd_ready, 1);
    // SP untouched: a PEEK still reads the old top of stack.
    do_cmd(2'b10, 3'd1, 0, 0, "rst_pop_peek");
    check("rst_pop_peek_val", reg_x, 16'h7777);

    // Back-to-back PUSHes with cmd_valid held.
    @(negedge clk);
    reg_sp = BASE; reg_a = 16'h0001; reg_x = 16'h0002;
    do_cmd(2'b00, 3'd0, 0, 0, "b2b_push_a");
    do_cmd(2'b00, 3'd1, 0, 1, "b2b_push_x");
    check("b2b_sp", reg_sp, 16'hFEFE);
    check("b2b_mem_feff", mem_read(16'hFEFF), 16'h0001);
    check("b2b_mem_fefe", mem_read(16'hFEFE), 16'h0002);

    // Randomized commands.
    for (int n = 0; n < 300; n++) begin
      int       r;
      int       gap;
      logic [1:0] op;
      logic [2:0] rg;
      gap = $urandom_range(1);
      if (gap != 0) @(negedge clk);
      reg_a = 16'($urandom);
      reg_x = 16'($urandom);
      reg_y = 16'($urandom);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(4))
          0: reg_sp = BASE;
          1: reg_sp = BASE - 16'd1;
          2: reg_sp = LIMIT;
          3: reg_sp = LIMIT + 16'd1;
          default: reg_sp = LIMIT + 16'($urandom_range(255));
        endcase
      end
      r  = $urandom_range(9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      rg = ($urandom_range(7) == 0) ? 3'(3 + $urandom_range(4)) : 3'($urandom_range(2));
      do_cmd(op, rg, $urandom_range(3), (gap != 0) ? 0 : 1, "rand");
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
